board_reset_sequencer: RTL and testbench
========================================

// Module: board_reset_sequencer
// PURPOSE
//  Board-level reset controller for FPGA system tops: combines power-on reset, a raw push-button
//  and a software reset request into NUM_DOMAINS active-high resets released in a fixed order
//  (e.g. core, SDRAM ctrl, Ethernet PHY) with programmable hold and inter-domain gaps.
//  Generalises the two-flop button synchroniser: adds debounce, minimum assert time, staged release, cause log.
// PARAMETERS
//  SYNC_STAGES       2      flops in reset-deassert and button synchronisers (>=2)
//  DEBOUNCE_CYCLES   65536  cycles synced button must hold a new level before it is accepted (>=1)
//  BUTTON_ACTIVE_LOW 1      1: io_button low = pressed; 0: high = pressed
//  MIN_ASSERT        256    cycles all resets stay asserted after last cause clears (>=1)
//  RELEASE_GAP       1024   cycles between successive domain releases (>=1)
//  NUM_DOMAINS       3      number of reset outputs (1..8); domain 0 released first
// PORTS
//  clock           in   1            system clock
//  reset           in   1            asynchronous, active-high (PLL not-locked / POR)
//  io_button       in   1            raw asynchronous push-button
//  io_sw_reset_req in   1            synchronous single-cycle request from CSR/watchdog
//  io_resets       out  NUM_DOMAINS  active-high domain resets
//  io_resets_n     out  NUM_DOMAINS  bitwise inverse of io_resets (PHY pins)
//  io_busy         out  1            high while any domain reset is asserted
//  io_cause        out  2            last cause: 0 POR, 1 button, 2 software
// BEHAVIOUR
//  - reset high: all flops clear asynchronously; io_resets all-1, io_resets_n all-0, io_busy 1,
//    io_cause 0, state ASSERT. Outputs react same instant, no clock needed.
//  - reset deassert passes SYNC_STAGES-flop chain; internal rst_s falls SYNC_STAGES edges later.
//  - Button: SYNC_STAGES sync then debounce; debounced level flips only after synced level differs
//    for DEBOUNCE_CYCLES consecutive cycles; counter restarts on any bounce. Debounced state resets to released.
//  - FSM states ASSERT, RELEASE, RUN (enum in package):
//    ASSERT: all io_resets=1; hold counter cleared while rst_s, pressed or sw_req; else counts;
//      at count==MIN_ASSERT-1 -> RELEASE, io_resets[0] clears on that edge, gap counter=0, idx=1.
//    RELEASE: gap counter counts; at RELEASE_GAP-1 clear io_resets[idx], idx++; after last
//      domain -> RUN same edge. NUM_DOMAINS==1 goes ASSERT->RUN directly.
//    RUN: io_resets all-0, io_busy 0.
//  - Any cause (debounced press, io_sw_reset_req) in RELEASE or RUN -> ASSERT; all io_resets=1
//    on the next edge; counters cleared. sw_req during ASSERT restarts hold count.
//  - io_cause updates on the edge a cause enters ASSERT; press and sw_req same cycle -> 1 (button wins).
//  - Release order strictly ascending; a higher domain never clears before a lower one.
//  - Counters sized $clog2(max+1); no wrap: compare-and-clear.
//  - io_busy = |io_resets; all outputs registered (no glitch on pins).
// STRUCTURE
//  - board_reset_pkg: state_e {ASSERT,RELEASE,RUN}, cause_e {CAUSE_POR,CAUSE_BUTTON,CAUSE_SW}.
//  - Sub-module debounce_sync (SYNC_STAGES, DEBOUNCE_CYCLES, ACTIVE_LOW): raw in -> clean pressed level.
//  - Top: reset-deassert sync chain, FSM, hold/gap counters, domain index, output register.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MIN_ASSERT=8, RELEASE_GAP=3, NUM_DOMAINS=3)
//  1. reset high mid-cycle -> io_resets=3'b111 immediately; deassert -> bit0 clears edge 10,
//     bit1 edge 13, bit2 edge 16; io_busy 0 at 16; io_cause=0.
//  2. In RUN, button pressed 3 cycles then bounces -> no change; pressed 6 cycles -> io_resets=111,
//     io_cause=1; after release+debounce, staged release repeats with same 8/3/3 timing.
//  3. io_sw_reset_req pulse in RUN -> io_resets=111 next edge, io_cause=2, release after 8 hold cycles.
//  4. sw_req while io_resets=3'b100 (RELEASE) -> 111 next edge; bits never clear out of order.
//  5. Debounced press and sw_req same cycle -> io_cause=1; button held 50 cycles -> resets stay 111.
//  6. reset pulse during RELEASE -> async all-1, io_cause=0, full sequence from test 1 reruns.

Source files
------------

// File: rtl/board_reset_pkg.sv
// ============================================================================
// Module : board_reset_pkg
// Brief  : Shared types and helpers for the board reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package board_reset_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_SW     = 2'd2
    } cause_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_sync.sv
// ============================================================================
// Module : debounce_sync
// Brief  : Synchronises a raw push-button and debounces it into a clean pressed level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_sync
    import board_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pressed
);

    localparam int                     CNT_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        level  = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
        cnt_d  = '0;
        deb_d  = deb_q;
        // Any sample agreeing with the accepted level restarts the run.
        if (level != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= SYNC_IDLE;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign pressed = deb_q;

endmodule

`default_nettype wire

// File: rtl/board_reset_sequencer.sv
// ============================================================================
// Module : board_reset_sequencer
// Brief  : Merges POR, push-button and software reset into staged domain resets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module board_reset_sequencer
    import board_reset_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int MIN_ASSERT        = 256,
    parameter int RELEASE_GAP       = 1024,
    parameter int NUM_DOMAINS       = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_button,
    input  logic                   io_sw_reset_req,
    output logic [NUM_DOMAINS-1:0] io_resets,
    output logic [NUM_DOMAINS-1:0] io_resets_n,
    output logic                   io_busy,
    output logic [1:0]             io_cause
);

    localparam int               HOLD_W    = cnt_width(MIN_ASSERT);
    localparam int               GAP_W     = cnt_width(RELEASE_GAP);
    localparam int               IDX_W     = cnt_width(NUM_DOMAINS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_ASSERT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic                   rst_s;
    logic                   pressed;
    logic                   trigger;

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] resets_q, resets_d;
    logic [NUM_DOMAINS-1:0] resets_n_q;
    logic                   busy_q;

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
    ) u_button (
        .clock   (clock),
        .reset   (reset),
        .raw     (io_button),
        .pressed (pressed)
    );

    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        rst_s      = rst_sync_q[SYNC_STAGES-1];
        trigger    = pressed | io_sw_reset_req;
        state_d    = state_q;
        cause_d    = cause_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        resets_d   = resets_q;

        case (state_q)
            ASSERT: begin
                resets_d = '1;
                if (rst_s || trigger) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    gap_d  = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_d  = RUN;
                        resets_d = '0;
                    end else begin
                        state_d     = RELEASE;
                        resets_d[0] = 1'b0;
                        idx_d       = IDX_W'(1);
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (trigger) begin
                    // Button wins when both causes arrive together.
                    state_d  = ASSERT;
                    resets_d = '1;
                    hold_d   = '0;
                    gap_d    = '0;
                    cause_d  = pressed ? CAUSE_BUTTON : CAUSE_SW;
                end else if (state_q == RUN) begin
                    resets_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_d           = '0;
                    resets_d[idx_q] = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d  = ASSERT;
                resets_d = '1;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_sync_q <= '1;
            state_q    <= ASSERT;
            cause_q    <= CAUSE_POR;
            hold_q     <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            resets_q   <= '1;
            resets_n_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            resets_q   <= resets_d;
            resets_n_q <= ~resets_d;
            busy_q     <= |resets_d;
        end
    end

    assign io_resets   = resets_q;
    assign io_resets_n = resets_n_q;
    assign io_busy     = busy_q;
    assign io_cause    = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_board_reset_sequencer.sv
// ============================================================================
// Module : tb_board_reset_sequencer
// Brief  : Scoreboard bench for board_reset_sequencer against a quiet-time model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MINA = 8;
    localparam int GAP  = 3;
    localparam int ND   = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          button = 1'b1;
    logic          sw_req = 1'b0;
    logic [ND-1:0] resets;
    logic [ND-1:0] resets_n;
    logic          busy;
    logic [1:0]    cause;

    board_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .BUTTON_ACTIVE_LOW (1'b1),
        .MIN_ASSERT        (MINA),
        .RELEASE_GAP       (GAP),
        .NUM_DOMAINS       (ND)
    ) dut (
        .clock           (clk),
        .reset           (reset),
        .io_button       (button),
        .io_sw_reset_req (sw_req),
        .io_resets       (resets),
        .io_resets_n     (resets_n),
        .io_busy         (busy),
        .io_cause        (cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] rst;
        logic [ND-1:0] rst_n;
        logic          busy;
        logic [1:0]    cause;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: domain d is out of reset once the board has been free of every
    // reset cause for MINA + d*GAP consecutive clock edges.
    int         quiet     = 0;
    int         since_rel = 0;
    logic [1:0] m_cause   = 2'd0;
    bit         m_deb     = 1'b0;
    bit         sync_pipe[SYNC];
    bit         recent[$];

    function automatic exp_t expected();
        exp_t e;
        for (int d = 0; d < ND; d++) e.rst[d] = (quiet < MINA + d * GAP);
        e.rst_n = ~e.rst;
        e.busy  = |e.rst;
        e.cause = m_cause;
        return e;
    endfunction

    initial begin
        bit rst_s;
        bit synced;
        bit all_differ;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                quiet     = 0;
                since_rel = 0;
                m_cause   = 2'd0;
                m_deb     = 1'b0;
                foreach (sync_pipe[i]) sync_pipe[i] = 1'b0;
                recent.delete();
            end else begin
                rst_s = (since_rel < SYNC);
                if (rst_s || m_deb || sw_req) begin
                    if (!rst_s && quiet >= MINA) m_cause = m_deb ? 2'd1 : 2'd2;
                    quiet = 0;
                end else if (quiet < 100000) begin
                    quiet++;
                end
                if (since_rel < 100000) since_rel++;
                synced = sync_pipe[SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) sync_pipe[i] = sync_pipe[i-1];
                sync_pipe[0] = (button == 1'b0);
                recent.push_back(synced);
                if (recent.size() > DEB) void'(recent.pop_front());
                if (recent.size() == DEB) begin
                    all_differ = 1'b1;
                    foreach (recent[i]) if (recent[i] == m_deb) all_differ = 1'b0;
                    if (all_differ) m_deb = !m_deb;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            exp_q.push_back(expected());
        end
    end

    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            #1;
            got = {resets, resets_n, busy, cause};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty @%0t: got resets=%b with no expected entry", $time, resets);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got resets=%b n=%b busy=%b cause=%0d, expected resets=%b n=%b busy=%b cause=%0d",
                             $time, resets, resets_n, busy, cause, e.rst, e.rst_n, e.busy, e.cause);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_resets(input logic [ND-1:0] v);
        int k;
        k = 0;
        while (resets !== v && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (resets !== v) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_resets @%0t: resets=%b never reached %b", $time, resets, v);
        end
    endtask

    task automatic pulse_reset(input int hold);
        exp_t e;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        e = expected();
        vectors++;
        if ({resets, resets_n, busy, cause} !== e) begin
            miscompares++;
            $display("FAIL async_reset @%0t: got resets=%b n=%b busy=%b cause=%0d, expected resets=%b n=%b busy=%b cause=%0d",
                     $time, resets, resets_n, busy, cause, e.rst, e.rst_n, e.busy, e.cause);
        end
        repeat (hold) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int burst;
        #1 reset = 1'b1;
        cyc(3);
        @(posedge clk);
        #2 reset = 1'b0;
        wait_resets('0);
        cyc(5);

        // Short bounce is ignored, then a real press restarts the sequence.
        button = 1'b0; cyc(3); button = 1'b1; cyc(10);
        button = 1'b0; cyc(6); button = 1'b1;
        wait_resets('0);
        cyc(3);

        // Software request from RUN.
        sw_req = 1'b1; cyc(1); sw_req = 1'b0;
        wait_resets('0);
        cyc(3);

        // Software request in the middle of the staged release.
        sw_req = 1'b1; cyc(1); sw_req = 1'b0;
        wait_resets(3'b100);
        sw_req = 1'b1; cyc(1); sw_req = 1'b0;
        wait_resets('0);
        cyc(3);

        // Debounced press and software request land on the same edge; long hold.
        button = 1'b0; cyc(6);
        sw_req = 1'b1; cyc(1); sw_req = 1'b0;
        cyc(43);
        button = 1'b1;
        wait_resets('0);
        cyc(3);

        // Board reset during the staged release.
        sw_req = 1'b1; cyc(1); sw_req = 1'b0;
        wait_resets(3'b110);
        pulse_reset(2);
        wait_resets('0);
        cyc(3);

        // Random bouncy button bursts and sporadic software requests.
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(2, 14);
            if (burst > 0) begin
                button = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
                burst--;
            end else begin
                button = 1'b1;
            end
            sw_req = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        button = 1'b1;
        sw_req = 1'b0;
        wait_resets('0);
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
